// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and helpers for the branch resolve unit: funct3 encodings,
// predictor counter reset value and saturation limits, and the branch decision.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT2_RESET = 2'b01;
    localparam logic [1:0] CNT2_MAX   = 2'b11;
    localparam logic [1:0] CNT2_MIN   = 2'b00;

    // funct3 010 and 011 have no conditional-branch meaning in RV32I.
    function automatic logic f3_legal(input logic [2:0] f3);
        return !((f3 == 3'b010) || (f3 == 3'b011));
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                         input logic lt, input logic ltu);
        logic cond;
        cond = 1'b0;
        case (f3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter2.sv
// Two-bit saturating up/down counter with enable; one entry of the predictor table.
module sat_counter2
    import branch_resolve_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    output logic [1:0] count
);

    logic [1:0] count_reg;
    logic [1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en) begin
            if (up) begin
                if (count_reg != CNT2_MAX) count_next = count_reg + 2'd1;
            end else begin
                if (count_reg != CNT2_MIN) count_next = count_reg - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_reg <= CNT2_RESET;
        else        count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches and jumps with a one-cycle registered result,
// trains a table of 2-bit predictors and keeps branch/misprediction statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    input  logic             req_valid,
    input  logic [2:0]       req_func3,
    input  logic             req_branch,
    input  logic             req_jump,
    input  logic [XLEN-1:0]  req_pc,
    input  logic             req_pred,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             res_illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       counters [DEPTH];
    logic [DEPTH-1:0] upd_sel;

    logic eq, lt, ltu, cond;
    logic cond_legal, illegal_c, taken_c, mispredict_c, upd_en;

    logic             res_valid_reg,      res_valid_next;
    logic             res_taken_reg,      res_taken_next;
    logic             res_mispredict_reg, res_mispredict_next;
    logic             res_illegal_reg,    res_illegal_next;
    logic [CNT_W-1:0] branch_cnt_reg,     branch_cnt_next;
    logic [CNT_W-1:0] mispred_cnt_reg,    mispred_cnt_next;

    // Word-aligned PCs: bits [1:0] and everything above the index are not used.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                              req_pc[XLEN-1:IDX_W+2], req_pc[1:0]};

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx    = req_pc[IDX_W+1:2];

    assign eq  = (op_a == op_b);
    assign lt  = ($signed(op_a) < $signed(op_b));
    assign ltu = (op_a < op_b);

    assign cond         = branch_cond(req_func3, eq, lt, ltu);
    assign cond_legal   = req_branch && !req_jump && f3_legal(req_func3);
    assign illegal_c    = req_branch && !req_jump && !f3_legal(req_func3);
    assign taken_c      = req_jump || (cond_legal && cond);
    assign mispredict_c = cond_legal && (cond != req_pred);
    assign upd_en       = req_valid && cond_legal;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
            assign upd_sel[gi] = upd_en && (upd_idx == IDX_W'(gi));
            sat_counter2 u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (upd_sel[gi]),
                .up    (cond),
                .count (counters[gi])
            );
        end
    endgenerate

    // Reads the registered table, so a same-cycle update shows up one cycle later.
    assign pred_taken = counters[lookup_idx][1];

    always_comb begin
        res_valid_next      = req_valid;
        res_taken_next      = res_taken_reg;
        res_mispredict_next = res_mispredict_reg;
        res_illegal_next    = res_illegal_reg;
        branch_cnt_next     = branch_cnt_reg;
        mispred_cnt_next    = mispred_cnt_reg;
        if (req_valid) begin
            res_taken_next      = taken_c;
            res_mispredict_next = mispredict_c;
            res_illegal_next    = illegal_c;
            if (cond_legal && (branch_cnt_reg != STAT_MAX))
                branch_cnt_next = branch_cnt_reg + 1'b1;
            if (mispredict_c && (mispred_cnt_reg != STAT_MAX))
                mispred_cnt_next = mispred_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_reg      <= 1'b0;
            res_taken_reg      <= 1'b0;
            res_mispredict_reg <= 1'b0;
            res_illegal_reg    <= 1'b0;
            branch_cnt_reg     <= '0;
            mispred_cnt_reg    <= '0;
        end else begin
            res_valid_reg      <= res_valid_next;
            res_taken_reg      <= res_taken_next;
            res_mispredict_reg <= res_mispredict_next;
            res_illegal_reg    <= res_illegal_next;
            branch_cnt_reg     <= branch_cnt_next;
            mispred_cnt_reg    <= mispred_cnt_next;
        end
    end

    assign res_valid      = res_valid_reg;
    assign res_taken      = res_taken_reg;
    assign res_mispredict = res_mispredict_reg;
    assign res_illegal    = res_illegal_reg;
    assign branch_cnt     = branch_cnt_reg;
    assign mispred_cnt    = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a driver pushes model-predicted results,
// a monitor pops and compares them whenever res_valid is seen.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [XLEN-1:0]  lookup_pc = '0;
    logic             pred_taken;
    logic             req_valid = 1'b0;
    logic [2:0]       req_func3 = '0;
    logic             req_branch = 1'b0;
    logic             req_jump = 1'b0;
    logic [XLEN-1:0]  req_pc = '0;
    logic             req_pred = 1'b0;
    logic [XLEN-1:0]  op_a = '0;
    logic [XLEN-1:0]  op_b = '0;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic             res_illegal;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .req_valid      (req_valid),
        .req_func3      (req_func3),
        .req_branch     (req_branch),
        .req_jump       (req_jump),
        .req_pc         (req_pc),
        .req_pred       (req_pred),
        .op_a           (op_a),
        .op_b           (op_b),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_illegal    (res_illegal),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit taken;
        bit misp;
        bit ill;
        int bc;
        int mc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   model_tab [DEPTH];
    int   m_bc;
    int   m_mc;
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int idx(input bit [31:0] pc);
        return int'((pc >> 2) & 32'(DEPTH - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_tab[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    // Reset asserted for one edge while a request is presented; that request is dropped.
    task automatic reset_dut();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_branch = 1'b1;
        req_jump   = 1'b0;
        req_func3  = 3'b000;
        op_a       = 32'd7;
        op_b       = 32'd7;
        req_pc     = 32'h0000_0040;
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
    endtask

    task automatic drive(input bit v, input bit [2:0] f3, input bit br, input bit jmp,
                         input bit [31:0] pc, input bit pred, input bit [31:0] a,
                         input bit [31:0] b, input bit [31:0] lpc);
        exp_t e;
        bit   cond;
        bit   legal;
        int   i;
        @(negedge clk);
        req_valid  = v;
        req_func3  = f3;
        req_branch = br;
        req_jump   = jmp;
        req_pc     = pc;
        req_pred   = pred;
        op_a       = a;
        op_b       = b;
        lookup_pc  = lpc;
        #1;
        check("pred_taken", longint'(pred_taken), longint'(model_tab[idx(lpc)] >= 2));
        if (v) begin
            case (f3)
                3'd0:    cond = (a == b);
                3'd1:    cond = (a != b);
                3'd4:    cond = ($signed(a) < $signed(b));
                3'd5:    cond = ($signed(a) >= $signed(b));
                3'd6:    cond = (a < b);
                3'd7:    cond = (a >= b);
                default: cond = 1'b0;
            endcase
            legal = (f3 != 3'd2) && (f3 != 3'd3);
            e.taken = 1'b0;
            e.misp  = 1'b0;
            e.ill   = 1'b0;
            if (jmp) begin
                e.taken = 1'b1;
            end else if (br && !legal) begin
                e.ill = 1'b1;
            end else if (br) begin
                e.taken = cond;
                e.misp  = (cond != pred);
                i = idx(pc);
                if (cond) model_tab[i] = (model_tab[i] < 3) ? model_tab[i] + 1 : 3;
                else      model_tab[i] = (model_tab[i] > 0) ? model_tab[i] - 1 : 0;
                if (m_bc < 65535) m_bc++;
                if (e.misp && m_mc < 65535) m_mc++;
            end
            e.bc = m_bc;
            e.mc = m_mc;
            q.push_back(e);
        end
    endtask

    task automatic idle(input bit [31:0] lpc);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, lpc);
    endtask

    // Monitor: rst_n only changes on negedges, so here it reflects the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) last = '{taken: 1'b0, misp: 1'b0, ill: 1'b0, bc: 0, mc: 0};
            if (res_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_res_valid actual=1 required=0 t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    txn++;
                    $display("txn %0d: taken=%0d misp=%0d ill=%0d bc=%0d mc=%0d (exp %0d %0d %0d %0d %0d)",
                             txn, res_taken, res_mispredict, res_illegal, branch_cnt, mispred_cnt,
                             e.taken, e.misp, e.ill, e.bc, e.mc);
                    check("res_taken", longint'(res_taken), longint'(e.taken));
                    check("res_mispredict", longint'(res_mispredict), longint'(e.misp));
                    check("res_illegal", longint'(res_illegal), longint'(e.ill));
                    check("branch_cnt", longint'(branch_cnt), longint'(e.bc));
                    check("mispred_cnt", longint'(mispred_cnt), longint'(e.mc));
                    last = e;
                end
            end else begin
                check("hold_taken", longint'(res_taken), longint'(last.taken));
                check("hold_mispredict", longint'(res_mispredict), longint'(last.misp));
                check("hold_illegal", longint'(res_illegal), longint'(last.ill));
                check("hold_branch_cnt", longint'(branch_cnt), longint'(last.bc));
                check("hold_mispred_cnt", longint'(mispred_cnt), longint'(last.mc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [31:0] pc;
        bit [31:0] a;
        bit [31:0] b;
        model_reset();
        reset_dut();
        idle(32'h40);

        // BEQ taken, predicted not-taken
        drive(1, 3'd0, 1, 0, 32'h0000_0000, 0, 32'd5, 32'd5, 32'h40);
        // Signed vs unsigned comparisons
        drive(1, 3'd4, 1, 0, 32'h0000_0200, 1, 32'hFFFF_FFFF, 32'd1, 32'h200);
        drive(1, 3'd6, 1, 0, 32'h0000_0204, 1, 32'hFFFF_FFFF, 32'd1, 32'h204);
        drive(1, 3'd5, 1, 0, 32'h0000_0208, 0, 32'hFFFF_FFFF, 32'd1, 32'h208);
        drive(1, 3'd7, 1, 0, 32'h0000_020C, 0, 32'hFFFF_FFFF, 32'd1, 32'h20C);
        // Four taken BNE saturate the counter, then one not-taken
        for (int i = 0; i < 4; i++)
            drive(1, 3'd1, 1, 0, 32'h0000_0080, 1, 32'd1, 32'd2, 32'h80);
        drive(1, 3'd1, 1, 0, 32'h0000_0080, 1, 32'd3, 32'd3, 32'h80);
        idle(32'h80);
        // Aliased update at 0x100 while looking up 0x0
        drive(1, 3'd0, 1, 0, 32'h0000_0100, 0, 32'd9, 32'd9, 32'h0);
        idle(32'h0);
        // Illegal funct3, jump priority, plain non-branch request
        drive(1, 3'd2, 1, 0, 32'h0000_0300, 0, 32'd1, 32'd1, 32'h300);
        drive(1, 3'd3, 1, 1, 32'h0000_0300, 0, 32'd1, 32'd2, 32'h300);
        drive(1, 3'd0, 0, 0, 32'h0000_0300, 1, 32'd1, 32'd1, 32'h300);
        idle(32'h300);
        // Reset with a request pending, then back-to-back traffic
        reset_dut();
        idle(32'h80);

        for (int n = 0; n < 300; n++) begin
            pc = $urandom;
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom
                                                     : 32'($urandom_range(0, 3)));
            drive(1'($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  pc & 32'h0000_03FF, 1'($urandom_range(0, 1)), a, b,
                  ($urandom_range(0, 1) == 0) ? (pc & 32'h0000_03FF) : ($urandom & 32'h0000_03FF));
            if (n == 150) reset_dut();
        end

        idle(32'h0);
        idle(32'h0);
        check("queue_drained", longint'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
